// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory path: word width, responder
// state encoding, default geometry and the address legality helper.
package mips_pkg;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } respState_t;

    // A word access is illegal when misaligned or beyond the last array word.
    function automatic logic addrIsBad(input logic [WORD_W-1:0] addr, input int idxW);
        return (addr[1:0] != 2'b00) || ((addr >> (idxW + 2)) != '0);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port DEPTH x 32 word store with write enable and a registered read port.
// Contents are deliberately left unreset.
module data_mem_array
    import mips_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one request at a time,
// fixed LATENCY, stall while outstanding. Define DATA_MEM_RESP_ERR_EN to flag bad addresses.
module data_mem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    respState_t       state;
    logic [CNT_W-1:0] cnt;
    logic             wrLat;
    logic             errLat;

    logic              accept;
    logic              reqErr;
    logic [IDX_W-1:0]  reqIdx;
    logic              commit;
    logic              commitWr;
    logic              commitErr;
    logic [IDX_W-1:0]  memAddr;
    logic [WORD_W-1:0] memWdata;
    logic [WORD_W-1:0] memRdata;
    logic              memWe;
    logic              memRe;

    assign accept = (state == IDLE) && req_valid;
    assign reqIdx = req_addr[IDX_W+1:2];

`ifdef DATA_MEM_RESP_ERR_EN
    assign reqErr = addrIsBad(req_addr, IDX_W);
`else
    assign reqErr = 1'b0;
`endif

    // With single-cycle latency the access commits on the acceptance edge,
    // so the array is fed straight from the request; otherwise from the latches.
    generate
        if (LATENCY == 1) begin : gDirect
            assign commit    = accept;
            assign commitWr  = req_write;
            assign commitErr = reqErr;
            assign memAddr   = reqIdx;
            assign memWdata  = req_wdata;
        end else begin : gLatched
            logic [IDX_W-1:0]  idxLat;
            logic [WORD_W-1:0] wdataLat;

            always_ff @(posedge clk) begin
                if (accept) begin
                    idxLat   <= reqIdx;
                    wdataLat <= req_wdata;
                end
            end

            assign commit    = (state == BUSY) && (cnt == CNT_ONE);
            assign commitWr  = wrLat;
            assign commitErr = errLat;
            assign memAddr   = idxLat;
            assign memWdata  = wdataLat;
        end
    endgenerate

    assign memWe = commit && commitWr && !commitErr;
    assign memRe = commit && !commitWr && !commitErr;

    data_mem_array #(
        .DEPTH(DEPTH)
    ) uArray (
        .clk  (clk),
        .we   (memWe),
        .re   (memRe),
        .addr (memAddr),
        .wdata(memWdata),
        .rdata(memRdata)
    );

    // cnt reaches zero on the commit edge, landing in RESP LATENCY cycles after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            wrLat  <= 1'b0;
            errLat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wrLat  <= req_write;
                        errLat <= reqErr;
                        cnt    <= CNT_LOAD;
                        state  <= (LATENCY > 1) ? BUSY : RESP;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && errLat;
    assign resp_rdata = (resp_valid && !wrLat && !errLat) ? memRdata : '0;
    assign stall      = req_valid && !resp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder with LATENCY=3 and LATENCY=1
// instances, checked against a word-addressed reference memory.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  reqValid;
    logic [1:0]  reqWrite;
    logic [31:0] reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic [1:0]  reqReady;
    logic [1:0]  respValid;
    logic [31:0] respRdata [2];
    logic [1:0]  respErr;
    logic [1:0]  stall;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[0]), .req_write(reqWrite[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .req_ready(reqReady[0]), .resp_valid(respValid[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0]), .stall(stall[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[1]), .req_write(reqWrite[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .req_ready(reqReady[1]), .resp_valid(respValid[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1]), .stall(stall[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference memory: key = instance * DEPTH + word index.
    logic [31:0] model [int];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int latOf(input int sel);
        return (sel == 0) ? 3 : 1;
    endfunction

    function automatic logic isBadAddr(input logic [31:0] a);
`ifdef DATA_MEM_RESP_ERR_EN
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int keyOf(input int sel, input logic [31:0] a);
        return sel * DEPTH + int'((a / 4) % DEPTH);
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that follows the response.
    task automatic txn(input int sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag);
        int          lat;
        int          key;
        logic        expErr;
        logic [31:0] expData;
        logic        known;
        lat     = latOf(sel);
        key     = keyOf(sel, addr);
        expErr  = isBadAddr(addr);
        expData = 32'h0;
        known   = 1'b1;
        if (!expErr) begin
            if (wr) model[key] = wdata;
            else if (model.exists(key)) expData = model[key];
            else known = 1'b0;
        end
        reqValid[sel] = 1'b1;
        reqWrite[sel] = wr;
        reqAddr[sel]  = addr;
        reqWdata[sel] = wdata;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            checkVal({tag, ".ready"}, 32'(reqReady[sel]),  32'(c == 0));
            checkVal({tag, ".valid"}, 32'(respValid[sel]), 32'(c == lat));
            checkVal({tag, ".stall"}, 32'(stall[sel]),     32'(c < lat));
            if (c == lat) begin
                checkVal({tag, ".err"}, 32'(respErr[sel]), 32'(expErr));
                if (known) checkVal({tag, ".rdata"}, respRdata[sel], expData);
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                reqWrite[sel] = ~wr;
                reqAddr[sel]  = $urandom;
                reqWdata[sel] = $urandom;
            end
        end
        reqValid[sel] = 1'b0;
    endtask

    task automatic idleCheck(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                checkVal({tag, ".valid"}, 32'(respValid[s]), 32'h0);
                checkVal({tag, ".ready"}, 32'(reqReady[s]),  32'h1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        reqValid = 2'b00;
        reqWrite = 2'b00;
        for (int s = 0; s < 2; s++) begin
            reqAddr[s]  = 32'h0;
            reqWdata[s] = 32'h0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checkVal("rst.ready", 32'(reqReady[s]),  32'h1);
            checkVal("rst.valid", 32'(respValid[s]), 32'h0);
            checkVal("rst.rdata", respRdata[s],      32'h0);
            checkVal("rst.err",   32'(respErr[s]),   32'h0);
            checkVal("rst.stall", 32'(stall[s]),     32'h0);
        end
        reqValid[0] = 1'b1;
        #1;
        checkVal("rst.stallFollow", 32'(stall[0]), 32'h1);
        reqValid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCheck(1, "postRst");

        // Directed: write then read back at LATENCY=3
        txn(0, 1'b1, 32'h40, 32'hDEADBEEF, "wr40");
        txn(0, 1'b0, 32'h40, 32'h0, "rd40");
        idleCheck(1, "after40");

        // Directed: LATENCY=1 back-to-back write/read
        txn(1, 1'b1, 32'h8, 32'h11, "l1wr8");
        txn(1, 1'b0, 32'h8, 32'h0, "l1rd8");
        txn(1, 1'b0, 32'h8, 32'h0, "l1rd8b");
        idleCheck(2, "afterL1");

        // Reset in the middle of BUSY drops the write
        txn(0, 1'b1, 32'h10, 32'h0, "pre10");
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 32'h10;
        reqWdata[0] = 32'hA5A5A5A5;
        @(negedge clk);
        checkVal("midRst.accept", 32'(reqReady[0]), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("midRst.busy",  32'(reqReady[0]),  32'h0);
        checkVal("midRst.noRsp", 32'(respValid[0]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkVal("midRst.ready", 32'(reqReady[0]),  32'h1);
        checkVal("midRst.valid", 32'(respValid[0]), 32'h0);
        reqValid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("midRst.hold", 32'(respValid[0]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCheck(3, "midRst.after");
        txn(0, 1'b0, 32'h10, 32'h0, "rd10");

        // Misaligned and out-of-range addresses
        txn(0, 1'b1, 32'h0,   32'h0,        "wr0");
        txn(0, 1'b1, 32'h400, 32'h12345678, "wr400");
        txn(0, 1'b0, 32'h0,   32'h0,        "rd0");
        txn(0, 1'b1, 32'h42,  32'hCAFEF00D, "wr42");
        txn(0, 1'b0, 32'h40,  32'h0,        "rd40b");
        txn(0, 1'b0, 32'h10,  32'h0,        "rd10b");
        txn(1, 1'b1, 32'h404, 32'h0BADCAFE, "l1wr404");
        txn(1, 1'b0, 32'h4,   32'h0,        "l1rd4");

        // Seed a window of words on both instances, then random traffic
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++)
                txn(s, 1'b1, 32'(w * 4), $urandom, "seed");
        for (int i = 0; i < 80; i++) begin
            int          sel;
            logic [31:0] a;
            int          r;
            sel = int'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 15)) * 4;
            r   = int'($urandom_range(0, 7));
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            if (r == 1) a = a + 32'h400 * 32'($urandom_range(1, 4));
            txn(sel, 1'($urandom_range(0, 1)), a, $urandom, "rand");
            if ($urandom_range(0, 3) == 0) idleCheck(1, "randIdle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
